wallace_mult_seq: RTL and testbench
===================================

Name: wallace_mult_seq

Overview:
- Iterative unsigned WIDTH x WIDTH multiplier built around one instance of the existing 4x4 combinational wallace_tree.
- Operands are split into 4-bit digits. One digit pair is multiplied per cycle, and each 8-bit partial product is shifted and accumulated into a 2*WIDTH result.
- Sits directly downstream of wallace_tree and consumes its prod output every cycle. This is the multi-cycle multiply unit the multdiv datapath calls with a start pulse.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of 4 and at least 4.
- DIGITS, WIDTH/4, derived: number of 4-bit digits per operand.
- ITERS, DIGITS*DIGITS, derived: number of accumulate cycles (16 at default).

Ports:
- clock  input  1  single rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- ctrl_MULT  input  1  start pulse; operands are sampled on the clock edge where it is high.
- data_operandA  input  WIDTH  multiplicand, unsigned.
- data_operandB  input  WIDTH  multiplier, unsigned.
- data_result  output  2*WIDTH  full unsigned product; held until the next completion.
- data_resultRDY  output  1  one-cycle pulse when data_result is updated.
- data_overflow  output  1  high when data_result[2*WIDTH-1:WIDTH] != 0; valid alongside data_result.
- busy  output  1  high while a multiply is in progress.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - data_result=0, data_resultRDY=0, data_overflow=0, busy=0.
  - Accumulator, digit counter and operand registers all =0.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - ctrl_MULT=1 at an edge latches A and B, clears the accumulator, sets cnt=0, moves to RUN, and sets busy=1.
- RUN (cycles cnt=0..ITERS-1):
  - i = cnt mod DIGITS; j = cnt / DIGITS.
  - wallace_tree inputs are A digit i and B digit j.
  - acc <= acc + (prod << 4*(i+j)), computed at 2*WIDTH bits with no truncation. This sum cannot overflow 2*WIDTH.
  - At the edge where cnt==ITERS-1:
    - data_result <= final sum, and data_overflow is derived from that final sum.
    - data_resultRDY <= 1, state -> DONE.
- DONE:
  - Lasts one cycle. At the next edge data_resultRDY <= 0, busy <= 0, state -> IDLE.
  - A ctrl_MULT seen in DONE is treated exactly as in IDLE: start the new operation. data_resultRDY still drops.
- Latency: ctrl_MULT sampled at edge N gives data_resultRDY=1 in the cycle after edge N+ITERS (edge N+16 at default). Throughput is one result per ITERS+1 cycles.
- ctrl_MULT while in RUN: abort the current operation, latch the new operands, restart at cnt=0. data_result is not updated and no data_resultRDY is produced for the aborted operation.
- Operand inputs are don't-care except on the start edge. Changes during RUN have no effect.
- data_result and data_overflow hold their value through IDLE and through subsequent RUN cycles until the next completion.
- Reset asserted mid-RUN: immediate return to the reset values, no data_resultRDY.
- Zero operands take the full latency (no early exit). This keeps latency fixed for the control FSM upstream.

Decomposition:
- Shared header/package holds:
  - DIGIT_W=4.
  - State encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - The multiply-latency constant, used by the multdiv control FSM.
- Sub-module: the existing wallace_tree (A[3:0], B[3:0], prod[7:0]), instantiated once. No new sub-module is needed.
- Digit select, shift and accumulate live in this block.

Test Plan:
- Reset, then ctrl_MULT with A=3, B=5 -> data_resultRDY pulses exactly once, 16 cycles after the start edge; data_result=15, data_overflow=0, busy low the cycle after the pulse.
- A=16'hFFFF, B=16'hFFFF -> data_result=32'hFFFE0001, data_overflow=1. Then A=16'h1234, B=0 -> data_result=0, data_overflow=0, same 16-cycle latency.
- Start A=100, B=200; at RUN cycle 7 pulse ctrl_MULT with A=7, B=9 -> only one data_resultRDY, 16 cycles after the second start, data_result=63.
- Start A=16'hABCD, B=16'h0002; assert reset at RUN cycle 5 -> all outputs 0 immediately, no data_resultRDY. Next start with A=2, B=2 -> data_result=4.
- Back-to-back: ctrl_MULT in the DONE cycle with A=255, B=256 -> previous result is valid on the pulse; new result 65280 arrives 16 cycles later.
- 1000 random operand pairs plus all 256 pairs of A,B in 0..15 -> data_result == A*B and data_overflow == (A*B > 16'hFFFF); the error count must be 0.

Source files
------------

// File: rtl/wallace_mult_seq_pkg.sv
// Shared constants and types for the iterative Wallace-tree multiplier.
// The multdiv control FSM imports this to learn the multiply latency.
package wallace_mult_seq_pkg;

  // Digit width matches the 4x4 wallace_tree core.
  localparam int DIGIT_W = 4;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // Number of accumulate cycles for a given operand width.
  function automatic int mult_latency(input int width);
    return (width / DIGIT_W) * (width / DIGIT_W);
  endfunction

  // Edges from the start edge to the edge that raises data_resultRDY, default width.
  localparam int MULT_LATENCY = mult_latency(16);

endpackage

// File: rtl/wallace_tree.sv
// 4x4 unsigned combinational multiplier.
// The four partial-product rows are reduced by two carry-save stages,
// followed by a single carry-propagate add.
module wallace_tree (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] prod
);

  logic [7:0] row0, row1, row2, row3;
  logic [7:0] sum1, carry1, sum2, carry2;

  // Partial-product generation and carry-save reduction down to two rows.
  always_comb begin
    row0   = B[0] ? {4'b0, A}       : 8'd0;
    row1   = B[1] ? {3'b0, A, 1'b0} : 8'd0;
    row2   = B[2] ? {2'b0, A, 2'b0} : 8'd0;
    row3   = B[3] ? {1'b0, A, 3'b0} : 8'd0;
    sum1   = row0 ^ row1 ^ row2;
    carry1 = ((row0 & row1) | (row0 & row2) | (row1 & row2)) << 1;
    sum2   = sum1 ^ carry1 ^ row3;
    carry2 = ((sum1 & carry1) | (sum1 & row3) | (carry1 & row3)) << 1;
    prod   = sum2 + carry2;
  end

endmodule

// File: rtl/wallace_mult_seq.sv
// Iterative unsigned WIDTH x WIDTH multiplier. One 4-bit digit pair goes
// through the shared wallace_tree per cycle; each partial product is shifted
// into place and summed into a 2*WIDTH accumulator. WIDTH must be a
// multiple of 4 and at least 4. Latency is fixed (no early exit on zero
// operands) so the upstream control FSM can count cycles.
module wallace_mult_seq
  import wallace_mult_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ctrl_MULT,
  input  logic [WIDTH-1:0]     data_operandA,
  input  logic [WIDTH-1:0]     data_operandB,
  output logic [2*WIDTH-1:0]   data_result,
  output logic                 data_resultRDY,
  output logic                 data_overflow,
  output logic                 busy
);

  localparam int DIGITS = WIDTH / DIGIT_W;
  localparam int ITERS  = DIGITS * DIGITS;
  localparam int CNT_W  = (ITERS > 1) ? $clog2(ITERS) : 1;

  mult_state_t              state;
  logic [WIDTH-1:0]         op_a;
  logic [WIDTH-1:0]         op_b;
  logic [2*WIDTH-1:0]       acc;
  logic [CNT_W-1:0]         cnt;

  logic [DIGIT_W-1:0]       a_digit;
  logic [DIGIT_W-1:0]       b_digit;
  logic [7:0]               prod;
  logic [2*WIDTH-1:0]       prod_wide;
  logic [2*WIDTH-1:0]       acc_next;
  int                       i_idx;
  int                       j_idx;

  wallace_tree u_tree (
    .A    (a_digit),
    .B    (b_digit),
    .prod (prod)
  );

  // Pick the current digit pair and form the shifted, accumulated sum.
  always_comb begin
    i_idx     = int'(cnt) % DIGITS;
    j_idx     = int'(cnt) / DIGITS;
    a_digit   = op_a[i_idx*DIGIT_W +: DIGIT_W];
    b_digit   = op_b[j_idx*DIGIT_W +: DIGIT_W];
    prod_wide = '0;
    prod_wide[7:0] = prod;
    acc_next  = acc + (prod_wide << (DIGIT_W * (i_idx + j_idx)));
  end

  // Controller: start/abort handling, accumulation and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      op_a           <= '0;
      op_b           <= '0;
      acc            <= '0;
      cnt            <= '0;
      data_result    <= '0;
      data_resultRDY <= 1'b0;
      data_overflow  <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_MULT) begin
        op_a  <= data_operandA;
        op_b  <= data_operandB;
        acc   <= '0;
        cnt   <= '0;
        busy  <= 1'b1;
        state <= RUN;
      end else begin
        case (state)
          RUN: begin
            acc <= acc_next;
            if (cnt == CNT_W'(ITERS - 1)) begin
              data_result    <= acc_next;
              data_overflow  <= |acc_next[2*WIDTH-1:WIDTH];
              data_resultRDY <= 1'b1;
              state          <= DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wallace_mult_seq.sv
// Self-checking bench for wallace_mult_seq: directed scenarios plus random
// and exhaustive-digit operands, checked by a scoreboard against plain
// integer multiplication.
module tb_wallace_mult_seq;

  localparam int WIDTH = 16;
  localparam int LAT   = 16;

  logic               clock;
  logic               reset;
  logic               ctrl_MULT;
  logic [WIDTH-1:0]   data_operandA;
  logic [WIDTH-1:0]   data_operandB;
  logic [2*WIDTH-1:0] data_result;
  logic               data_resultRDY;
  logic               data_overflow;
  logic               busy;

  typedef struct {
    longint unsigned prod;
    bit              ovf;
    longint          due;
  } exp_t;

  exp_t   sb[$];
  int     n_checks = 0;
  int     n_pass   = 0;
  longint cycle    = 0;

  wallace_mult_seq #(.WIDTH(WIDTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .data_overflow  (data_overflow),
    .busy           (busy)
  );

  // Free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Edge counter used to timestamp starts and completions.
  always @(posedge clock) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input longint unsigned actual,
                             input longint unsigned expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                  name, actual, expected, cycle);
  endtask

  // Caller is at a falling edge; the start is sampled on the next rising edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input bit abort);
    exp_t e;
    longint unsigned p;
    p = longint'(a) * longint'(b);
    e.prod = p;
    e.ovf  = (p > 64'hFFFF);
    e.due  = cycle + 1 + LAT;
    if (abort && sb.size() > 0) void'(sb.pop_back());
    sb.push_back(e);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    data_operandA = WIDTH'($urandom);
    data_operandB = WIDTH'($urandom);
  endtask

  // Returns at the falling edge where data_resultRDY is high.
  task automatic waitResult();
    for (int k = 0; k < 3 * LAT; k++) begin
      if (data_resultRDY) break;
      @(negedge clock);
    end
    if (!data_resultRDY) checkOutput("rdy_timeout", 0, 1);
  endtask

  task automatic runOp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    applyStimulus(a, b, 1'b0);
    waitResult();
  endtask

  // Monitor: every completion must match the oldest outstanding operation.
  always @(negedge clock) begin
    if (!reset && data_resultRDY) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_rdy", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("result", data_result, e.prod);
        checkOutput("overflow", data_overflow, e.ovf);
        checkOutput("latency", cycle, e.due);
      end
    end
  end

  // Directed scenarios followed by exhaustive-digit and random sweeps.
  initial begin
    logic [WIDTH-1:0] ra, rb;
    reset = 1'b1; ctrl_MULT = 1'b0; data_operandA = '0; data_operandB = '0;
    repeat (3) @(negedge clock);
    checkOutput("rst_result", data_result, 0);
    checkOutput("rst_rdy", data_resultRDY, 0);
    checkOutput("rst_ovf", data_overflow, 0);
    checkOutput("rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] basic 3*5");
    runOp(16'd3, 16'd5);
    @(negedge clock);
    checkOutput("busy_after_rdy", busy, 0);
    checkOutput("rdy_single_pulse", data_resultRDY, 0);
    checkOutput("hold_result", data_result, 15);
    repeat (3) @(negedge clock);

    $display("[TB] max operands and zero operand");
    runOp(16'hFFFF, 16'hFFFF);
    @(negedge clock);
    checkOutput("hold_ovf", data_overflow, 1);
    runOp(16'h1234, 16'h0000);
    @(negedge clock);

    $display("[TB] abort in RUN");
    applyStimulus(16'd100, 16'd200, 1'b0);
    repeat (6) @(negedge clock);
    checkOutput("busy_in_run", busy, 1);
    applyStimulus(16'd7, 16'd9, 1'b1);
    waitResult();
    @(negedge clock);
    checkOutput("abort_result", data_result, 63);
    repeat (LAT + 4) @(negedge clock);

    $display("[TB] reset mid-run");
    applyStimulus(16'hABCD, 16'h0002, 1'b0);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    #1;
    sb.delete();
    checkOutput("midrst_result", data_result, 0);
    checkOutput("midrst_ovf", data_overflow, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_rdy", data_resultRDY, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (LAT + 4) @(negedge clock);
    runOp(16'd2, 16'd2);
    @(negedge clock);

    $display("[TB] back-to-back start in DONE");
    runOp(16'd1000, 16'd3);
    runOp(16'd255, 16'd256);
    @(negedge clock);
    checkOutput("b2b_result", data_result, 65280);

    $display("[TB] exhaustive digit sweep");
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        runOp(WIDTH'(a), WIDTH'(b));

    $display("[TB] random operands");
    for (int k = 0; k < 1000; k++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if ((k % 16) == 3) ra = '1;
      if ((k % 16) == 7) rb = '1;
      if ((k % 32) == 11) rb = WIDTH'($urandom_range(0, 255));
      runOp(ra, rb);
    end
    repeat (3) @(negedge clock);

    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
